// File: rtl/biteval_seq_sched_if.sv
// Handshake/bus bundle for biteval_seq_sched: input vector, evaluator port, result word.
// master = surrounding datapath (producer, evaluator, consumer); slave = the scheduler.
interface biteval_seq_sched_if #(
   parameter int IN_W  = 1894,
   parameter int OUT_W = 128,
   parameter int IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_vec;
   logic [IN_W-1:0]  ev_vec;
   logic             ev_req;
   logic [IDX_W-1:0] ev_idx;
   logic             ev_bit;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_vec;
   logic             busy;

   modport master (
      output in_valid, in_vec, ev_bit, out_ready,
      input  in_ready, ev_vec, ev_req, ev_idx, out_valid, out_vec, busy
   );

   modport slave (
      input  in_valid, in_vec, ev_bit, out_ready,
      output in_ready, ev_vec, ev_req, ev_idx, out_valid, out_vec, busy
   );
endinterface

// File: rtl/biteval_seq_sched.sv
// Time-multiplexes one fixed-latency per-bit evaluator across OUT_W output bits.
// Optional mismatch counter against a reference word: define BITEVAL_CHECK_EN.
module biteval_seq_sched #(
   parameter int IN_W  = 1894,
   parameter int OUT_W = 128,
   parameter int LAT   = 2,
   parameter int IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   biteval_seq_sched_if.slave   bus
`ifdef BITEVAL_CHECK_EN
   ,
   input  logic [OUT_W-1:0]     exp_vec,
   output logic [31:0]          err_cnt,
   output logic                 err_last
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] HOLD  = 2'd3;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_W - 1);

   logic [1:0]       state;
   logic [IDX_W-1:0] cnt;
   logic [IN_W-1:0]  ev_vec_q;
   logic [OUT_W-1:0] out_vec_q;

   logic             ret_valid;
   logic [IDX_W-1:0] ret_idx;
   logic             drain_done;

   generate
      if (LAT == 0) begin : g_no_pipe
         assign ret_valid  = (state == ISSUE);
         assign ret_idx    = cnt;
         assign drain_done = 1'b1;
      end else begin : g_pipe
         logic [LAT-1:0]   pipe_v;
         logic [IDX_W-1:0] pipe_idx [LAT];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pipe_v <= '0;
               for (int unsigned i = 0; i < LAT; i++) pipe_idx[i] <= '0;
            end else begin
               pipe_v[0]   <= (state == ISSUE);
               pipe_idx[0] <= cnt;
               for (int unsigned i = 1; i < LAT; i++) begin
                  pipe_v[i]   <= pipe_v[i-1];
                  pipe_idx[i] <= pipe_idx[i-1];
               end
            end
         end

         assign ret_valid = pipe_v[LAT-1];
         assign ret_idx   = pipe_idx[LAT-1];
         // Done when only the exiting stage may still be valid: its bit lands on this edge.
         assign drain_done = (LAT'(pipe_v << 1) == '0);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         ev_vec_q  <= '0;
         out_vec_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  ev_vec_q  <= bus.in_vec;
                  out_vec_q <= '0;
                  cnt       <= '0;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (cnt == LAST_IDX) begin
                  cnt   <= '0;
                  state <= (LAT > 0) ? DRAIN : HOLD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DRAIN: begin
               if (drain_done) state <= HOLD;
            end
            HOLD: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (ret_valid) out_vec_q[ret_idx] <= bus.ev_bit;
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.ev_req    = (state == ISSUE);
   assign bus.ev_idx    = cnt;
   assign bus.ev_vec    = ev_vec_q;
   assign bus.out_valid = (state == HOLD);
   assign bus.out_vec   = out_vec_q;
   assign bus.busy      = (state != IDLE);

`ifdef BITEVAL_CHECK_EN
   logic [OUT_W-1:0] exp_q;
   logic [31:0]      mis_cnt;
   logic [32:0]      err_sum;

   always_comb begin
      mis_cnt = '0;
      for (int unsigned i = 0; i < OUT_W; i++) begin
         mis_cnt = mis_cnt + 32'(out_vec_q[i] ^ exp_q[i]);
      end
      err_sum = {1'b0, err_cnt} + {1'b0, mis_cnt};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q    <= '0;
         err_cnt  <= '0;
         err_last <= 1'b0;
      end else begin
         if (state == IDLE && bus.in_valid) exp_q <= exp_vec;
         if (state == HOLD && bus.out_ready) begin
            err_cnt  <= err_sum[32] ? '1 : err_sum[31:0];
            err_last <= (out_vec_q != exp_q);
         end
      end
   end
`endif

endmodule

// File: tb/tb_biteval_seq_sched.sv
// Directed bench for biteval_seq_sched: OUT_W=4/LAT=2 and OUT_W=3/LAT=0 instances.
// Mismatch-counter checks are compiled in when BITEVAL_CHECK_EN is defined.
module tb_biteval_seq_sched;

   logic clk;
   logic rst;
   int   vecs;
   int   fails;

   biteval_seq_sched_if #(.IN_W(8), .OUT_W(4), .IDX_W(2)) bus_a ();
   biteval_seq_sched_if #(.IN_W(4), .OUT_W(3), .IDX_W(2)) bus_b ();

`ifdef BITEVAL_CHECK_EN
   logic [3:0]  exp_vec_a;
   logic [31:0] err_cnt_a;
   logic        err_last_a;
   logic [2:0]  exp_vec_b;
   logic [31:0] err_cnt_b;
   logic        err_last_b;
`endif

   biteval_seq_sched #(.IN_W(8), .OUT_W(4), .LAT(2), .IDX_W(2)) dut_a (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_a)
`ifdef BITEVAL_CHECK_EN
      ,
      .exp_vec  (exp_vec_a),
      .err_cnt  (err_cnt_a),
      .err_last (err_last_a)
`endif
   );

   biteval_seq_sched #(.IN_W(4), .OUT_W(3), .LAT(0), .IDX_W(2)) dut_b (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_b)
`ifdef BITEVAL_CHECK_EN
      ,
      .exp_vec  (exp_vec_b),
      .err_cnt  (err_cnt_b),
      .err_last (err_last_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Evaluator A: 2-cycle latency, returns the inverse of ev_vec[idx].
   logic [1:0] a_d1;
   logic [1:0] a_d2;
   always_ff @(posedge clk) begin
      a_d1 <= bus_a.ev_idx;
      a_d2 <= a_d1;
   end
   assign bus_a.ev_bit = ~bus_a.ev_vec[a_d2];

   // Evaluator B: zero latency, always 1.
   assign bus_b.ev_bit = 1'b1;

   logic b_idx_over;
   initial b_idx_over = 1'b0;
   always_ff @(posedge clk) begin
      if (bus_b.ev_req && bus_b.ev_idx >= 2'd3) b_idx_over <= 1'b1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vecs++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      vecs  = 0;
      fails = 0;
      rst   = 1'b1;
      bus_a.in_valid  = 1'b0;
      bus_a.in_vec    = '0;
      bus_a.out_ready = 1'b0;
      bus_b.in_valid  = 1'b0;
      bus_b.in_vec    = '0;
      bus_b.out_ready = 1'b0;
`ifdef BITEVAL_CHECK_EN
      exp_vec_a = '0;
      exp_vec_b = '0;
`endif
      tick;
      tick;
      chk("rst_a_in_ready",  bus_a.in_ready, 1);
      chk("rst_a_ev_req",    bus_a.ev_req, 0);
      chk("rst_a_ev_idx",    bus_a.ev_idx, 0);
      chk("rst_a_ev_vec",    bus_a.ev_vec, 0);
      chk("rst_a_out_valid", bus_a.out_valid, 0);
      chk("rst_a_out_vec",   bus_a.out_vec, 0);
      chk("rst_a_busy",      bus_a.busy, 0);
      chk("rst_b_in_ready",  bus_b.in_ready, 1);
`ifdef BITEVAL_CHECK_EN
      chk("rst_a_err_cnt",   err_cnt_a, 0);
      chk("rst_a_err_last",  err_last_a, 0);
`endif
      rst = 1'b0;

      // B: OUT_W=3, LAT=0, accept at cycle T
      tick;
      bus_b.in_valid = 1'b1;
      bus_b.in_vec   = 4'h5;
`ifdef BITEVAL_CHECK_EN
      exp_vec_b = 3'b111;
`endif
      tick;
      bus_b.in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("b_ev_req",    bus_b.ev_req, 1);
         chk("b_ev_idx",    bus_b.ev_idx, k);
         chk("b_out_valid_early", bus_b.out_valid, 0);
         tick;
      end
      chk("b_out_valid", bus_b.out_valid, 1);
      chk("b_out_vec",   bus_b.out_vec, 3'b111);
      chk("b_ev_req_hold", bus_b.ev_req, 0);
      bus_b.out_ready = 1'b1;
      tick;
      bus_b.out_ready = 1'b0;
      chk("b_in_ready_after", bus_b.in_ready, 1);
`ifdef BITEVAL_CHECK_EN
      chk("b_err_cnt",  err_cnt_b, 0);
      chk("b_err_last", err_last_b, 0);
`endif

      // A: accept 1010 at cycle 0 -> issue 1..4, out_valid cycle 7, word 0101
      bus_a.in_valid = 1'b1;
      bus_a.in_vec   = 8'hFA;
`ifdef BITEVAL_CHECK_EN
      exp_vec_a = 4'b0010;
`endif
      chk("a_in_ready_c0", bus_a.in_ready, 1);
      tick;
      bus_a.in_valid = 1'b0;
      chk("a_ev_vec",   bus_a.ev_vec, 8'hFA);
      chk("a_busy",     bus_a.busy, 1);
      chk("a_in_ready_issue", bus_a.in_ready, 0);
      for (int k = 0; k < 4; k++) begin
         chk("a_ev_req", bus_a.ev_req, 1);
         chk("a_ev_idx", bus_a.ev_idx, k);
         tick;
      end
      chk("a_drain_req_c5",   bus_a.ev_req, 0);
      chk("a_drain_valid_c5", bus_a.out_valid, 0);
      tick;
      chk("a_drain_valid_c6", bus_a.out_valid, 0);
      tick;
      chk("a_out_valid_c7", bus_a.out_valid, 1);
      chk("a_out_vec_c7",   bus_a.out_vec, 4'b0101);

      // back-pressure for 10 cycles
      for (int k = 0; k < 10; k++) begin
         chk("bp_out_vec",   bus_a.out_vec, 4'b0101);
         chk("bp_out_valid", bus_a.out_valid, 1);
         chk("bp_in_ready",  bus_a.in_ready, 0);
         chk("bp_ev_req",    bus_a.ev_req, 0);
         tick;
      end
      bus_a.out_ready = 1'b1;
      chk("bp_in_ready_same", bus_a.in_ready, 0);
      tick;
      bus_a.out_ready = 1'b0;
      chk("bp_in_ready_next",  bus_a.in_ready, 1);
      chk("bp_out_valid_next", bus_a.out_valid, 0);
      chk("bp_busy_next",      bus_a.busy, 0);
`ifdef BITEVAL_CHECK_EN
      chk("chk1_err_cnt",  err_cnt_a, 3);
      chk("chk1_err_last", err_last_a, 1);
`endif

      // in_valid held high with changing in_vec
      bus_a.in_valid = 1'b1;
      bus_a.in_vec   = 8'h33;
`ifdef BITEVAL_CHECK_EN
      exp_vec_a = 4'b1100;
`endif
      tick;
      for (int k = 0; k < 6; k++) begin
         chk("held_ev_vec", bus_a.ev_vec, 8'h33);
         bus_a.in_vec = 8'(8'h40 + 17 * k);
         tick;
      end
      chk("held_out_valid", bus_a.out_valid, 1);
      chk("held_out_vec",   bus_a.out_vec, 4'b1100);
      chk("held_ev_vec_hold", bus_a.ev_vec, 8'h33);
      chk("held_in_ready",  bus_a.in_ready, 0);
      bus_a.in_vec    = 8'h58;
`ifdef BITEVAL_CHECK_EN
      exp_vec_a = 4'b0111;
`endif
      bus_a.out_ready = 1'b1;
      tick;
      bus_a.out_ready = 1'b0;
      chk("held_in_ready_idle", bus_a.in_ready, 1);
      chk("held_ev_vec_idle",   bus_a.ev_vec, 8'h33);
`ifdef BITEVAL_CHECK_EN
      chk("chk2_err_cnt",  err_cnt_a, 3);
      chk("chk2_err_last", err_last_a, 0);
`endif
      tick;
      bus_a.in_valid = 1'b0;
      chk("held2_ev_vec", bus_a.ev_vec, 8'h58);
      chk("held2_ev_idx", bus_a.ev_idx, 0);
      chk("held2_ev_req", bus_a.ev_req, 1);
      repeat (6) tick;
      chk("held2_out_valid", bus_a.out_valid, 1);
      chk("held2_out_vec",   bus_a.out_vec, 4'b0111);
      bus_a.out_ready = 1'b1;
      tick;
      bus_a.out_ready = 1'b0;
`ifdef BITEVAL_CHECK_EN
      chk("chk3_err_cnt",  err_cnt_a, 3);
      chk("chk3_err_last", err_last_a, 0);
`endif

      // asynchronous reset in the third ISSUE cycle
      bus_a.in_valid = 1'b1;
      bus_a.in_vec   = 8'h96;
      tick;
      bus_a.in_valid = 1'b0;
      tick;
      tick;
      chk("ar_pre_idx", bus_a.ev_idx, 2);
      #2 rst = 1'b1;
      #1;
      chk("ar_in_ready",  bus_a.in_ready, 1);
      chk("ar_ev_req",    bus_a.ev_req, 0);
      chk("ar_ev_idx",    bus_a.ev_idx, 0);
      chk("ar_ev_vec",    bus_a.ev_vec, 0);
      chk("ar_out_valid", bus_a.out_valid, 0);
      chk("ar_out_vec",   bus_a.out_vec, 0);
      chk("ar_busy",      bus_a.busy, 0);
`ifdef BITEVAL_CHECK_EN
      chk("ar_err_cnt",   err_cnt_a, 0);
`endif
      tick;
      chk("ar_out_valid_held", bus_a.out_valid, 0);
      rst = 1'b0;
      bus_a.in_valid = 1'b1;
      bus_a.in_vec   = 8'h3C;
`ifdef BITEVAL_CHECK_EN
      exp_vec_a = 4'b0011;
`endif
      tick;
      bus_a.in_valid = 1'b0;
      chk("ar2_ev_vec", bus_a.ev_vec, 8'h3C);
      repeat (6) tick;
      chk("ar2_out_valid", bus_a.out_valid, 1);
      chk("ar2_out_vec",   bus_a.out_vec, 4'b0011);
      bus_a.out_ready = 1'b1;
      tick;
      bus_a.out_ready = 1'b0;
`ifdef BITEVAL_CHECK_EN
      chk("ar2_err_cnt",  err_cnt_a, 0);
      chk("ar2_err_last", err_last_a, 0);
`endif

      chk("b_idx_range", b_idx_over, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
